id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline stage that directly feeds the ALU. Captures decoded

---
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID -> EX stage bus: upstream handshake and decoded fields, writeback bypass,
// flush, and the downstream handshake toward the ALU.
interface id_ex_stage_if #(
   parameter int XLEN = 64,
   parameter int OPW  = 4,
   parameter int RW   = 5
);
   // control
   logic            flush_i_idex;
   // upstream (ID side)
   logic            valid_i_idex;
   logic            ready_o_idex;
   logic [OPW-1:0]  aluop_i_idex;
   logic [XLEN-1:0] op1_i_idex;
   logic [XLEN-1:0] op2_i_idex;
   logic [RW-1:0]   rs1_i_idex;
   logic [RW-1:0]   rs2_i_idex;
   logic            use_rs1_i_idex;
   logic            use_rs2_i_idex;
   logic [RW-1:0]   rd_i_idex;
   logic            wen_i_idex;
   // writeback bypass bus
   logic            fwd_wen_i_idex;
   logic [RW-1:0]   fwd_rd_i_idex;
   logic [XLEN-1:0] fwd_data_i_idex;
   // downstream (EX side)
   logic            valid_o_idex;
   logic            ready_i_idex;
   logic [OPW-1:0]  aluop_o_idex;
   logic [XLEN-1:0] op1_o_idex;
   logic [XLEN-1:0] op2_o_idex;
   logic [RW-1:0]   rd_o_idex;
   logic            wen_o_idex;

   // Environment view: drives ID/bypass/EX-ready, observes the stage outputs.
   modport master (
      output flush_i_idex, valid_i_idex, aluop_i_idex, op1_i_idex, op2_i_idex,
             rs1_i_idex, rs2_i_idex, use_rs1_i_idex, use_rs2_i_idex,
             rd_i_idex, wen_i_idex, fwd_wen_i_idex, fwd_rd_i_idex,
             fwd_data_i_idex, ready_i_idex,
      input  ready_o_idex, valid_o_idex, aluop_o_idex, op1_o_idex,
             op2_o_idex, rd_o_idex, wen_o_idex
   );

   // Stage view.
   modport slave (
      input  flush_i_idex, valid_i_idex, aluop_i_idex, op1_i_idex, op2_i_idex,
             rs1_i_idex, rs2_i_idex, use_rs1_i_idex, use_rs2_i_idex,
             rd_i_idex, wen_i_idex, fwd_wen_i_idex, fwd_rd_i_idex,
             fwd_data_i_idex, ready_i_idex,
      output ready_o_idex, valid_o_idex, aluop_o_idex, op1_o_idex,
             op2_o_idex, rd_o_idex, wen_o_idex
   );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: 2-entry skid buffer (head + skid) between ID and
// the ALU, with operand patching from the writeback bypass bus both when an
// instruction is captured and every cycle while it is held.
module id_ex_stage #(
   parameter int XLEN = 64,
   parameter int OPW  = 4,
   parameter int RW   = 5
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   typedef struct packed {
      logic [OPW-1:0]  aluop;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
      logic            use_rs1;
      logic            use_rs2;
      logic [RW-1:0]   rd;
      logic            wen;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

   occ_e   state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t in_e, cap_e, head_held, skid_held;
   logic   accept, pop;

   // Replace operands whose source register is being written on the bypass
   // bus this cycle; x0 is hard-wired and never forwarded.
   function automatic entry_t patch(input entry_t          e,
                                    input logic            fwen,
                                    input logic [RW-1:0]   frd,
                                    input logic [XLEN-1:0] fdata);
      entry_t r;
      r = e;
      if (fwen && e.use_rs1 && (e.rs1 != '0) && (e.rs1 == frd)) r.op1 = fdata;
      if (fwen && e.use_rs2 && (e.rs2 != '0) && (e.rs2 == frd)) r.op2 = fdata;
      return r;
   endfunction

   // Handshake qualifiers; ready_o depends only on registered occupancy.
   assign accept = bus.valid_i_idex & (state_q != TWO) & ~bus.flush_i_idex;
   assign pop    = (state_q != EMPTY) & bus.ready_i_idex;

   // Incoming entry; a write to x0 is squashed so EX never sees it.
   always_comb begin
      in_e.aluop   = bus.aluop_i_idex;
      in_e.op1     = bus.op1_i_idex;
      in_e.op2     = bus.op2_i_idex;
      in_e.rs1     = bus.rs1_i_idex;
      in_e.rs2     = bus.rs2_i_idex;
      in_e.use_rs1 = bus.use_rs1_i_idex;
      in_e.use_rs2 = bus.use_rs2_i_idex;
      in_e.rd      = bus.rd_i_idex;
      in_e.wen     = bus.wen_i_idex & (bus.rd_i_idex != '0);
   end

   assign cap_e     = patch(in_e,   bus.fwd_wen_i_idex, bus.fwd_rd_i_idex, bus.fwd_data_i_idex);
   assign head_held = patch(head_q, bus.fwd_wen_i_idex, bus.fwd_rd_i_idex, bus.fwd_data_i_idex);
   assign skid_held = patch(skid_q, bus.fwd_wen_i_idex, bus.fwd_rd_i_idex, bus.fwd_data_i_idex);

   // Next occupancy and entry contents; flush overrides accept and pop.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               head_d  = cap_e;
               state_d = ONE;
            end
         end
         ONE: begin
            head_d = head_held;
            if (accept && pop) begin
               head_d = cap_e;
            end else if (accept) begin
               skid_d  = cap_e;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            head_d = head_held;
            skid_d = skid_held;
            if (pop) begin
               head_d  = skid_held;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (bus.flush_i_idex) state_d = EMPTY;
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep all registers updating from
      // the same pre-edge values regardless of process ordering.
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Entry data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: data is reset too, because the head drives the outputs and
      // they must read zero straight out of reset.
      if (!rst_n) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         head_q <= head_d;
         skid_q <= skid_d;
      end
   end

   assign bus.ready_o_idex = (state_q != TWO);
   assign bus.valid_o_idex = (state_q != EMPTY);
   assign bus.aluop_o_idex = head_q.aluop;
   assign bus.op1_o_idex   = head_q.op1;
   assign bus.op2_o_idex   = head_q.op2;
   assign bus.rd_o_idex    = head_q.rd;
   assign bus.wen_o_idex   = head_q.wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, streaming, backpressure, bypass,
// flush and x0 write suppression, with hand-computed expected values.
module tb_id_ex_stage;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   id_ex_stage_if #(.XLEN(64), .OPW(4), .RW(5)) bus ();

   id_ex_stage #(.XLEN(64), .OPW(4), .RW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] aluop, input logic [63:0] op1, input logic [63:0] op2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic wen);
      bus.valid_i_idex   = 1'b1;
      bus.aluop_i_idex   = aluop;
      bus.op1_i_idex     = op1;
      bus.op2_i_idex     = op2;
      bus.rs1_i_idex     = rs1;
      bus.rs2_i_idex     = rs2;
      bus.use_rs1_i_idex = u1;
      bus.use_rs2_i_idex = u2;
      bus.rd_i_idex      = rd;
      bus.wen_i_idex     = wen;
   endtask

   task automatic idle();
      bus.valid_i_idex = 1'b0;
   endtask

   task automatic fwd(input logic en, input logic [4:0] rd, input logic [63:0] data);
      bus.fwd_wen_i_idex  = en;
      bus.fwd_rd_i_idex   = rd;
      bus.fwd_data_i_idex = data;
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.flush_i_idex = 1'b0;
      bus.ready_i_idex = 1'b0;
      send(4'h0, 64'h0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      idle();
      fwd(1'b0, 5'd0, 64'h0);
      #3;
      check("rst_valid", bus.valid_o_idex, 1'b0);
      check("rst_ready", bus.ready_o_idex, 1'b1);
      check("rst_op1",   bus.op1_o_idex,   64'h0);
      #9 rst_n = 1'b1;

      // Stream: four back-to-back with EX always ready.
      bus.ready_i_idex = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(4'(i + 1), 64'h100 + 64'(i), 64'h200, 5'd0, 5'd0, 1'b0, 1'b0, 5'(i + 1), 1'b1);
         step();
         check("stream_valid", bus.valid_o_idex, 1'b1);
         check("stream_op1",   bus.op1_o_idex,   64'h100 + 64'(i));
         check("stream_aluop", bus.aluop_o_idex, 4'(i + 1));
         check("stream_ready", bus.ready_o_idex, 1'b1);
      end
      idle();
      step();
      check("stream_drain", bus.valid_o_idex, 1'b0);

      // Backpressure: A,B fill the buffer, C waits at the input.
      bus.ready_i_idex = 1'b0;
      send(4'h1, 64'hA, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
      step();
      send(4'h2, 64'hB, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
      step();
      check("bp_ready_full", bus.ready_o_idex, 1'b0);
      check("bp_head_a",     bus.op1_o_idex,   64'hA);
      send(4'h3, 64'hC, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
      step();
      check("bp_hold_a",     bus.op1_o_idex,   64'hA);
      check("bp_hold_ready", bus.ready_o_idex, 1'b0);
      bus.ready_i_idex = 1'b1;
      step();
      check("bp_head_b",     bus.op1_o_idex,   64'hB);
      check("bp_ready_back", bus.ready_o_idex, 1'b1);
      step();
      check("bp_head_c",     bus.op1_o_idex,   64'hC);
      check("bp_valid_c",    bus.valid_o_idex, 1'b1);
      idle();
      step();
      check("bp_drain",      bus.valid_o_idex, 1'b0);

      // Bypass at capture, then while held.
      bus.ready_i_idex = 1'b0;
      send(4'h4, 64'h11, 64'h33, 5'd5, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1);
      fwd(1'b1, 5'd5, 64'hDEAD);
      step();
      check("byp_capture", bus.op1_o_idex, 64'hDEAD);
      check("byp_op2_kept", bus.op2_o_idex, 64'h33);
      idle();
      fwd(1'b0, 5'd5, 64'h5555);
      step();
      check("byp_no_wen", bus.op1_o_idex, 64'hDEAD);
      fwd(1'b1, 5'd5, 64'hBEEF);
      step();
      check("byp_held", bus.op1_o_idex, 64'hBEEF);
      fwd(1'b0, 5'd0, 64'h0);
      bus.ready_i_idex = 1'b1;
      step();
      check("byp_drain", bus.valid_o_idex, 1'b0);

      // x0 source is never bypassed, at capture or while held.
      bus.ready_i_idex = 1'b0;
      send(4'h5, 64'h22, 64'h0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1);
      fwd(1'b1, 5'd0, 64'h999);
      step();
      check("byp_x0_capture", bus.op1_o_idex, 64'h22);
      idle();
      step();
      check("byp_x0_held", bus.op1_o_idex, 64'h22);

      // Skid entry patched as it moves to head.
      send(4'h6, 64'h0, 64'h44, 5'd0, 5'd9, 1'b0, 1'b1, 5'd8, 1'b1);
      fwd(1'b0, 5'd0, 64'h0);
      step();
      idle();
      fwd(1'b1, 5'd9, 64'h9999);
      bus.ready_i_idex = 1'b1;
      step();
      check("byp_skid_move", bus.op2_o_idex, 64'h9999);
      fwd(1'b0, 5'd0, 64'h0);
      step();
      check("byp_skid_drain", bus.valid_o_idex, 1'b0);

      // Flush with full buffer and an incoming instruction.
      bus.ready_i_idex = 1'b0;
      send(4'h1, 64'hF1, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
      step();
      send(4'h2, 64'hF2, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
      step();
      send(4'h3, 64'hD0, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
      bus.flush_i_idex = 1'b1;
      step();
      check("flush_valid", bus.valid_o_idex, 1'b0);
      check("flush_ready", bus.ready_o_idex, 1'b1);
      bus.flush_i_idex = 1'b0;
      idle();
      bus.ready_i_idex = 1'b1;
      step();
      check("flush_dropped", bus.valid_o_idex, 1'b0);

      // Write to x0 is suppressed; a real rd keeps its enable.
      bus.ready_i_idex = 1'b0;
      send(4'h7, 64'h70, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
      step();
      check("rd0_valid", bus.valid_o_idex, 1'b1);
      check("rd0_wen",   bus.wen_o_idex,   1'b0);
      send(4'h8, 64'h77, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1);
      step();
      idle();
      bus.ready_i_idex = 1'b1;
      step();
      check("rd3_rd",  bus.rd_o_idex,  5'd3);
      check("rd3_wen", bus.wen_o_idex, 1'b1);
      step();

      // Asynchronous reset while the buffer is full.
      bus.ready_i_idex = 1'b0;
      send(4'h9, 64'hE1, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
      step();
      send(4'hA, 64'hE2, 64'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
      step();
      check("pre_rst_full", bus.ready_o_idex, 1'b0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", bus.valid_o_idex, 1'b0);
      check("arst_ready", bus.ready_o_idex, 1'b1);
      check("arst_aluop", bus.aluop_o_idex, 4'h0);
      check("arst_op1",   bus.op1_o_idex,   64'h0);
      check("arst_op2",   bus.op2_o_idex,   64'h0);
      check("arst_rd",    bus.rd_o_idex,    5'd0);
      check("arst_wen",   bus.wen_o_idex,   1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
